// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations are carried out on magnitudes; the result signs are
// captured at launch and applied in a single fix-up cycle after the loop.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;   // quotient / product must be negated
  logic                 neg_rem_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]     b_mag_q;
  logic [2*WIDTH-1:0]   acc_q;       // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, div_zero_q;

  // Operand signs and magnitudes at launch; unsigned ops never negate.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sign_a = ~op[0] & srcA[WIDTH-1];
  assign sign_b = ~op[0] & srcB[WIDTH-1];
  assign a_mag  = sign_a ? (WIDTH'(0) - srcA) : srcA;
  assign b_mag  = sign_b ? (WIDTH'(0) - srcB) : srcB;

  // One shift-add step: add multiplicand when the current multiplier bit is 1,
  // then shift the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the quotient bit in at the bottom.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, b_mag_q};
  assign div_diff  = div_shift - {1'b0, b_mag_q};
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ge};

  // Sign-corrected results presented to HI/LO at the fix-up edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               b_is_zero;
  assign prod_fix  = neg_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
  assign quot_fix  = neg_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  // With a zero divisor every step subtracts nothing, so the remainder ends up
  // as |srcA| and re-applying the dividend sign reproduces srcA exactly.
  assign rem_fix   = neg_rem_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  assign b_is_zero = (b_mag_q == '0);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, fix-up, and MTHI/MTLO writes.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: every register here is plain control/data state, so all of it is
    // reset; an abandoned operation leaves nothing behind in HI/LO.
    if (!reset_n) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // pre-edge values, independent of statement order.
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            b_mag_q   <= b_mag;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= is_div_q ? div_next : mul_next;
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            hi_q       <= rem_fix;
            lo_q       <= b_is_zero ? '1 : quot_fix;
            div_zero_q <= b_is_zero;
          end else begin
            hi_q       <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q       <= prod_fix[WIDTH-1:0];
            div_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32): a table of directed
// operations with hand-computed HI/LO, plus sequences for back-to-back launch,
// ignored start while busy, MTHI/MTLO, and reset mid-operation.
module tb_mips_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clock, reset_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [W-1:0] a, b, exp_hi, exp_lo;
    logic       exp_dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a launch request in the current cycle and step past its start edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (sampled 1 time unit after each edge).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!done && n < 100);
  endtask

  int n;
  int pulses;

  initial begin
    vecs[0]  = '{"mult_7_m3",      MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"multu_max",      MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{"div_5_0",        DIV,   32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{"mult_m5_m3",     MULT,  32'hFFFFFFFB, 32'hFFFFFFFD, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[4]  = '{"div_ovf",        DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"mult_min_min",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{"divu_100_7",     DIVU,  32'h64,       32'h7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[7]  = '{"div_7_m2",       DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{"divu_max_1",     DIVU,  32'hFFFFFFFF, 32'h1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{"div_m5_0",       DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{"multu_2p16",     MULTU, 32'h10000,    32'h10000,    32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{"divu_0_0",       DIVU,  32'h0,        32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b1};

    reset_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MULT; srcA = '0; srcB = '0; wdata = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dz",   64'(div_zero), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven operations.
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      srcA = 32'hDEADBEEF; srcB = 32'h12345678;  // later changes must not matter
      wait_done(n);
      check({vecs[i].name, "_lat"}, 64'(n), 64'(LAT));
      check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
      check({vecs[i].name, "_dz"}, 64'(div_zero), 64'(vecs[i].exp_dz));
      @(posedge clock); #1;
      check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
    end

    // Back-to-back: DIV -7/2 then DIVU 7/2 launched in the done cycle.
    launch(DIV, 32'hFFFFFFF9, 32'h2);
    wait_done(n);
    check("b2b_div_lat", 64'(n), 64'(LAT));
    check("b2b_div_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    launch(DIVU, 32'h7, 32'h2);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(n);
    check("b2b_divu_lat", 64'(n), 64'(LAT));
    check("b2b_divu_hilo", {hi, lo}, {32'h1, 32'h3});

    // Start and srcA changes while busy are ignored; MTHI while busy ignored.
    launch(MULT, 32'h3, 32'h4);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1; srcA = 32'h99; op = DIVU; hi_we = 1'b1; wdata = 32'hABCD;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0;
    check("busy_hi_we_ignored", 64'(hi), 64'(32'h1));
    wait_done(n);
    check("busy_start_lat", 64'(n + 5), 64'(LAT));
    check("busy_start_hilo", {hi, lo}, {32'h0, 32'hC});
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("busy_start_single_done", 64'(pulses), 64'd0);

    // MTLO / MTHI while idle.
    lo_we = 1'b1; wdata = 32'h55;
    @(posedge clock); #1;
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'(32'h55));
    hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clock); #1;
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'hAA, 32'h55});

    // MTLO together with an accepted start lands, then the result overwrites it.
    lo_we = 1'b1; wdata = 32'h77;
    launch(MULTU, 32'h6, 32'h7);
    lo_we = 1'b0;
    check("mtlo_with_start", 64'(lo), 64'(32'h77));
    wait_done(n);
    check("mtlo_overwritten", {hi, lo}, {32'h0, 32'h2A});

    // Reset in the middle of a DIV abandons it.
    launch(DIV, 32'h64, 32'h3);
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done || busy) pulses++;
    end
    check("midreset_no_done", 64'(pulses), 64'd0);
    check("midreset_hilo_kept", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
